// File: rtl/dsm_sample_sched_if.sv
// Upstream sample stream into the delta-sigma scheduler: data with a valid/ready handshake.
interface dsm_sample_sched_if #(
  parameter int DAC_RES = 24
);
  logic [DAC_RES-1:0] s_data;
  logic               s_valid;
  logic               s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/dsm_sample_sched.sv
// Sample scheduler for the 1-bit delta-sigma DAC modulator: tick generation, one-entry
// sample buffer, OSR-tick sample hold, underrun fill and modulator reset sequencing.
module dsm_sample_sched #(
  parameter int DAC_RES = 24,
  parameter int CLK_DIV = 4,
  parameter int OSR     = 64,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  dsm_sample_sched_if.slave  s_if,
  output logic               dac_clk_o,
  output logic [DAC_RES-1:0] dac_din_o,
  output logic               dac_rst_o,
  output logic               busy_o,
  output logic               underrun_o,
  output logic [CNT_W-1:0]   underrun_cnt_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int OSR_W = $clog2(OSR);
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [OSR_W-1:0]   OSR_LAST = OSR_W'(OSR - 1);
  localparam logic [DAC_RES-1:0] MID      = {1'b1, {(DAC_RES-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [OSR_W-1:0]   osr_cnt_q, osr_cnt_d;
  logic [DAC_RES-1:0] buf_q, buf_d;
  logic               buf_vld_q, buf_vld_d;
  logic [DAC_RES-1:0] din_q, din_d;
  logic               drst_q, drst_d;
  logic               under_q, under_d;
  logic [CNT_W-1:0]   ucnt_q, ucnt_d;
  logic               tick;
  logic               accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign tick   = (div_cnt_q == DIV_LAST);
  assign accept = s_if.s_valid & s_if.s_ready;

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      div_cnt_q <= '0;
      osr_cnt_q <= '0;
      buf_vld_q <= 1'b0;
      din_q     <= MID;
      drst_q    <= 1'b1;
      under_q   <= 1'b0;
      ucnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      osr_cnt_q <= osr_cnt_d;
      buf_vld_q <= buf_vld_d;
      din_q     <= din_d;
      drst_q    <= drst_d;
      under_q   <= under_d;
      ucnt_q    <= ucnt_d;
    end
  end

  // buffer payload is only meaningful while buf_vld_q is set, so it needs no reset
  always_ff @(posedge clk_i) begin
    buf_q <= buf_d;
  end

  // next-state logic
  always_comb begin
    state_d   = state_q;
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    osr_cnt_d = osr_cnt_q;
    buf_d     = buf_q;
    buf_vld_d = buf_vld_q;
    din_d     = din_q;
    drst_d    = drst_q;
    under_d   = 1'b0;
    ucnt_d    = ucnt_q;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (en_i && buf_vld_q) begin
            din_d     = buf_q;
            buf_vld_d = 1'b0;
            osr_cnt_d = '0;
            drst_d    = 1'b0;
            state_d   = RUN;
          end
        end
        RUN: begin
          if (osr_cnt_q == OSR_LAST) begin
            osr_cnt_d = '0;
            if (!en_i) begin
              state_d = IDLE;
              din_d   = MID;
              drst_d  = 1'b1;
            end else if (buf_vld_q) begin
              din_d     = buf_q;
              buf_vld_d = 1'b0;
            end else begin
              din_d   = MID;
              under_d = 1'b1;
              ucnt_d  = sat_inc(ucnt_q);
            end
          end else begin
            osr_cnt_d = osr_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // ready is only high with the buffer empty, so a load never collides with a drain
    if (accept) begin
      buf_d     = s_if.s_data;
      buf_vld_d = 1'b1;
    end
  end

  // outputs
  always_comb begin
    s_if.s_ready   = ~buf_vld_q & en_i & ~rst_i;
    dac_clk_o      = tick & ~rst_i;
    dac_din_o      = din_q;
    dac_rst_o      = drst_q;
    busy_o         = (state_q == RUN);
    underrun_o     = under_q;
    underrun_cnt_o = ucnt_q;
  end

endmodule

// File: tb/tb_dsm_sample_sched.sv
// Bench for dsm_sample_sched: vector table, scripted corner sequences, randomized run vs reference model.
module tb_dsm_sample_sched;
  localparam int DAC_RES = 8;
  localparam int CLK_DIV = 4;
  localparam int OSR     = 4;
  localparam int CNT_W   = 2;
  localparam int UMAX    = (1 << CNT_W) - 1;
  localparam logic [7:0] MID = 8'h80;
  localparam int LOGN    = 300;

  logic       clk;
  logic       rst;
  logic       en;
  logic       dac_clk;
  logic [7:0] dac_din;
  logic       dac_rst;
  logic       busy;
  logic       upulse;
  logic [1:0] ucnt;

  dsm_sample_sched_if #(.DAC_RES(DAC_RES)) sif ();

  dsm_sample_sched #(
    .DAC_RES(DAC_RES), .CLK_DIV(CLK_DIV), .OSR(OSR), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .s_if(sif),
    .dac_clk_o(dac_clk), .dac_din_o(dac_din), .dac_rst_o(dac_rst),
    .busy_o(busy), .underrun_o(upulse), .underrun_cnt_o(ucnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit model_on = 0;

  // sampled outputs of the most recent cycle
  bit       o_rdy, o_clk, o_drst, o_busy, o_up;
  logic [7:0] o_din;
  int       o_ucnt;

  logic [7:0] din_log  [LOGN];
  bit         clk_log  [LOGN];
  bit         drst_log [LOGN];
  bit         rdy_log  [LOGN];
  bit         busy_log [LOGN];
  bit         up_log   [LOGN];
  int         ucnt_log [LOGN];

  // reference model: a sample plays for OSR ticks, counted down; the buffer is a queue
  int         m_since;
  bit         m_play;
  int         m_left;
  logic [7:0] m_q[$];
  logic [7:0] m_din;
  bit         m_drst;
  bit         m_up;
  int         m_ucnt;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  function automatic bit m_tick(input bit r);
    return !r && ((m_since % CLK_DIV) == CLK_DIV - 1);
  endfunction

  function automatic bit m_rdy(input bit r, input bit e);
    return (m_q.size() == 0) && e && !r;
  endfunction

  task automatic m_update(input bit r, input bit e, input bit v, input logic [7:0] d);
    bit acc;
    if (r) begin
      m_since = 0; m_play = 0; m_left = 0; m_q.delete();
      m_din = MID; m_drst = 1; m_up = 0; m_ucnt = 0;
    end else begin
      acc  = v && m_rdy(r, e);
      m_up = 0;
      if (m_tick(r)) begin
        if (!m_play) begin
          if (e && m_q.size() > 0) begin
            m_din = m_q.pop_front(); m_play = 1; m_left = OSR; m_drst = 0;
          end
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_left = OSR;
            if (!e) begin
              m_play = 0; m_din = MID; m_drst = 1;
            end else if (m_q.size() > 0) begin
              m_din = m_q.pop_front();
            end else begin
              m_din = MID; m_up = 1;
              if (m_ucnt < UMAX) m_ucnt++;
            end
          end
        end
      end
      if (acc) m_q.push_back(d);
      m_since++;
    end
  endtask

  task automatic step(input bit r, input bit e, input bit v, input logic [7:0] d);
    rst = r; en = e; sif.s_valid = v; sif.s_data = d;
    @(negedge clk);
    o_rdy = sif.s_ready; o_clk = dac_clk; o_din = dac_din; o_drst = dac_rst;
    o_busy = busy; o_up = upulse; o_ucnt = int'(ucnt);
    if (cyc >= 0 && cyc < LOGN) begin
      din_log[cyc] = o_din; clk_log[cyc] = o_clk; drst_log[cyc] = o_drst;
      rdy_log[cyc] = o_rdy; busy_log[cyc] = o_busy; up_log[cyc] = o_up;
      ucnt_log[cyc] = o_ucnt;
    end
    if (model_on) begin
      chk($sformatf("m_rdy@%0d", cyc),  o_rdy,  m_rdy(r, e));
      chk($sformatf("m_clk@%0d", cyc),  o_clk,  m_tick(r));
      chk($sformatf("m_din@%0d", cyc),  o_din,  m_din);
      chk($sformatf("m_drst@%0d", cyc), o_drst, m_drst);
      chk($sformatf("m_busy@%0d", cyc), o_busy, m_play);
      chk($sformatf("m_up@%0d", cyc),   o_up,   m_up);
      chk($sformatf("m_ucnt@%0d", cyc), o_ucnt, m_ucnt);
    end
    @(posedge clk);
    m_update(r, e, v, d);
    #1;
    cyc++;
  endtask

  typedef struct {
    bit r, e, v;
    logic [7:0] d;
    bit x_clk;
    logic [7:0] x_din;
    bit x_drst, x_rdy, x_busy;
  } vec_t;

  vec_t tbl[18];
  logic [7:0] pq[$];

  initial begin
    bit e, v, r;
    logic [7:0] d;

    // vectors: reset cycle, idle with en low, then the first load
    tbl[0] = '{1, 1, 1, 8'h10, 0, MID, 1, 0, 0};
    for (int k = 1; k <= 12; k++) tbl[k] = '{0, 0, 0, 8'h00, (k % 4 == 0), MID, 1, 0, 0};
    tbl[13] = '{0, 1, 1, 8'h10, 0, MID,   1, 1, 0};
    tbl[14] = '{0, 1, 1, 8'h20, 0, MID,   1, 0, 0};
    tbl[15] = '{0, 1, 1, 8'h20, 0, MID,   1, 0, 0};
    tbl[16] = '{0, 1, 1, 8'h20, 1, MID,   1, 0, 0};
    tbl[17] = '{0, 1, 1, 8'h20, 0, 8'h10, 0, 1, 1};

    rst = 1; en = 0; sif.s_valid = 0; sif.s_data = '0;
    cyc = -2;
    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    model_on = 1;

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].v, tbl[i].d);
      chk($sformatf("t_clk[%0d]", i),  o_clk,  tbl[i].x_clk);
      chk($sformatf("t_din[%0d]", i),  o_din,  tbl[i].x_din);
      chk($sformatf("t_drst[%0d]", i), o_drst, tbl[i].x_drst);
      chk($sformatf("t_rdy[%0d]", i),  o_rdy,  tbl[i].x_rdy);
      chk($sformatf("t_busy[%0d]", i), o_busy, tbl[i].x_busy);
      chk($sformatf("t_ucnt[%0d]", i), o_ucnt, 0);
    end

    // scripted run: stream, underrun, saturation, late sample, en drop, reset mid-RUN
    pq.push_back(8'h30);
    pq.push_back(8'h40);
    while (cyc <= 216) begin
      if (cyc == 150) pq.push_back(8'h55);
      if (cyc == 162) pq.push_back(8'h60);
      if (cyc == 178) pq.push_back(8'h70);
      if (cyc == 205) pq.push_back(8'h11);
      e = !(cyc >= 185 && cyc <= 200);
      r = (cyc == 210);
      v = (pq.size() > 0) && !r;
      d = v ? pq[0] : 8'h00;
      step(r, e, v, d);
      if (v && o_rdy) void'(pq.pop_front());
    end

    for (int n = 17; n <= 80; n++) begin
      logic [7:0] exp_d;
      case ((n - 17) / 16)
        0: exp_d = 8'h10;
        1: exp_d = 8'h20;
        2: exp_d = 8'h30;
        default: exp_d = 8'h40;
      endcase
      chk($sformatf("stream_din@%0d", n), din_log[n], exp_d);
      chk($sformatf("stream_up@%0d", n), up_log[n], 0);
    end
    chk("under_din",   din_log[81], MID);
    chk("under_pulse", up_log[81], 1);
    chk("under_cnt1",  ucnt_log[81], 1);
    chk("under_busy",  busy_log[81], 1);
    chk("under_pulse_end", up_log[82], 0);
    chk("under_cnt2",  ucnt_log[97], 2);
    chk("under_cnt3",  ucnt_log[113], 3);
    chk("sat_pulse",   up_log[145], 1);
    chk("sat_cnt",     ucnt_log[145], 3);
    chk("late_pre",    din_log[159], MID);
    chk("late_din",    din_log[161], 8'h55);
    chk("late_up",     up_log[161], 0);
    for (int n = 177; n <= 192; n++) chk($sformatf("endrop_din@%0d", n), din_log[n], 8'h60);
    chk("endrop_idle_din",  din_log[193], MID);
    chk("endrop_idle_drst", drst_log[193], 1);
    chk("endrop_idle_busy", busy_log[193], 0);
    chk("endrop_idle_rdy",  rdy_log[193], 0);
    chk("reen_rdy_bufheld", rdy_log[201], 0);
    chk("reen_busy",        busy_log[201], 0);
    chk("reen_din",         din_log[205], 8'h70);
    chk("reen_drst",        drst_log[205], 0);
    chk("reen_busy_run",    busy_log[205], 1);
    chk("rst_rdy_low",      rdy_log[210], 0);
    chk("rst_busy",         busy_log[211], 0);
    chk("rst_din",          din_log[211], MID);
    chk("rst_drst",         drst_log[211], 1);
    chk("rst_buf_empty",    rdy_log[211], 1);
    chk("rst_ucnt",         ucnt_log[211], 0);
    chk("rst_clk1",         clk_log[211], 0);
    chk("rst_clk3",         clk_log[213], 0);
    chk("rst_clk4",         clk_log[214], 1);
    chk("rst_no_load",      busy_log[215], 0);

    // randomized traffic against the model
    e = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(63) == 0) e = !e;
      r = ($urandom_range(299) == 0);
      v = ($urandom_range(2) != 0);
      d = 8'($urandom);
      step(r, e, v, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
